// File: rtl/bht_pkg.sv
// Shared types for the speculative branch history tracker.
package bht_pkg;

    // Tracker control state: normal operation, or rolling the table back
    // after a mispredict.
    typedef enum logic {
        IDLE   = 1'b0,
        REPAIR = 1'b1
    } bht_state_e;

endpackage : bht_pkg

// File: rtl/bht_ckpt_fifo.sv
// Circular checkpoint buffer for in-flight branches. It supports push at the
// tail, pop at the head, and a full clear. The head can be read, and any slot
// can be read at rd_ptr for the repair walk.
module bht_ckpt_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [WIDTH-1:0]           rd_data,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH)-1:0]   head_ptr,
    output logic [$clog2(DEPTH)-1:0]   tail_ptr,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    // Write the checkpoint slot at the tail.
    // NOTE: storage has no reset; a slot is only read while it lies between
    // head and tail, and it is always written before it gets there.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping. DEPTH is a power of two, so the
    // pointers wrap on their own.
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then see pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (clear) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (push) tail_ptr <= tail_ptr + 1'b1;
            if (pop)  head_ptr <= head_ptr + 1'b1;
            count <= count + PW'(push) - PW'(pop);
        end
    end

    assign rd_data   = mem[rd_ptr];
    assign head_data = mem[head_ptr];

endmodule : bht_ckpt_fifo

// File: rtl/spec_bht.sv
// Speculative branch history tracker. Predicted outcomes are shifted into the
// history table when they are predicted. A checkpoint FIFO remembers each
// branch's prior history. Branches resolve oldest-first. A mispredict rewinds
// the table by walking the FIFO from youngest to oldest. The walk then
// reapplies the oldest branch with its actual direction.
module spec_bht
    import bht_pkg::*;
#(
    parameter int IWIDTH = 6,
    parameter int HWIDTH = 6,
    parameter int DEPTH  = 4,
    parameter int GLOBAL = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [IWIDTH-1:0]        index,
    output logic [HWIDTH-1:0]        out,
    input  logic                     spec_valid,
    input  logic [IWIDTH-1:0]        spec_index,
    input  logic                     spec_taken,
    output logic                     spec_ready,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     res_ready,
    output logic                     res_mispredict,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int AW      = $clog2(DEPTH);
    localparam int PW      = AW + 1;
    localparam int ENTRIES = 2 ** IWIDTH;
    localparam int EW      = IWIDTH + HWIDTH + 1;

    typedef struct packed {
        logic [IWIDTH-1:0] index;
        logic [HWIDTH-1:0] old;
        logic              taken;
    } ckpt_t;

    // In global mode every access goes to entry 0. The remaining entries
    // never leave reset and drop out as constants.
    function automatic logic [IWIDTH-1:0] eff(input logic [IWIDTH-1:0] i);
        return (GLOBAL != 0) ? '0 : i;
    endfunction

    logic [HWIDTH-1:0] tbl [ENTRIES];

    bht_state_e        state, state_next;
    logic [AW-1:0]     ptr, ptr_next;
    logic              dir, dir_next;

    ckpt_t             push_e, head_e, rd_e;
    logic [AW-1:0]     head_ptr, tail_ptr;
    logic [PW-1:0]     count;
    logic [HWIDTH-1:0] spec_old;

    logic push_acc, res_acc, pop, clear, repair_step, at_head;

    assign spec_old = tbl[eff(spec_index)];
    assign push_e   = '{index: spec_index, old: spec_old, taken: spec_taken};

    // Readiness depends only on registered state, so a same-cycle pop can
    // never open a slot for a push.
    assign spec_ready     = en && (state == IDLE) && (count != PW'(DEPTH));
    assign res_ready      = en && (state == IDLE) && (count != '0);
    assign push_acc       = spec_valid && spec_ready;
    assign res_acc        = res_valid && res_ready;
    assign res_mispredict = res_acc && (res_taken != head_e.taken);
    assign pop            = res_acc && !res_mispredict;

    assign repair_step = en && (state == REPAIR);
    assign at_head     = (ptr == head_ptr);
    assign clear       = repair_step && at_head;

    assign busy    = (state == REPAIR);
    assign pending = count;
    assign out     = tbl[eff(index)];

    bht_ckpt_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push_acc),
        .push_data (push_e),
        .pop       (pop),
        .clear     (clear),
        .rd_ptr    (ptr),
        .rd_data   (rd_e),
        .head_data (head_e),
        .head_ptr  (head_ptr),
        .tail_ptr  (tail_ptr),
        .count     (count)
    );

    // Next-state logic: enter REPAIR on a mispredict and walk back to the head.
    // NOTE: every variable gets a default before the case, so no path leaves
    // one unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        dir_next   = dir;
        case (state)
            IDLE: begin
                if (res_mispredict) begin
                    state_next = REPAIR;
                    // A push accepted at the same edge becomes the youngest
                    // entry, so the walk starts at the old tail slot.
                    ptr_next   = push_acc ? tail_ptr : tail_ptr - 1'b1;
                    dir_next   = res_taken;
                end
            end
            REPAIR: begin
                if (at_head) state_next = IDLE;
                else         ptr_next   = ptr - 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control state register; en=0 freezes the walk in place.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            ptr   <= '0;
            dir   <= 1'b0;
        end else if (en) begin
            state <= state_next;
            ptr   <= ptr_next;
            dir   <= dir_next;
        end
    end

    // History table: a speculative shift on push, or one restore per repair
    // step. The walk restores youngest-first, so aliased entries end at the
    // oldest saved value. The head is then shifted with the actual direction.
    // Pushes only occur in IDLE and repairs only in REPAIR, so one write port
    // suffices.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) tbl[i] <= '0;
        end else if (push_acc) begin
            tbl[eff(spec_index)] <= {spec_old[HWIDTH-2:0], spec_taken};
        end else if (repair_step) begin
            tbl[eff(rd_e.index)] <= at_head ? {rd_e.old[HWIDTH-2:0], dir} : rd_e.old;
        end
    end

endmodule : spec_bht

// File: tb/tb_spec_bht.sv
// Self-checking bench for spec_bht. A transaction-level model keeps a
// snapshot of the whole table per in-flight branch. A scoreboard queue holds
// the predicted direction and snapshot pushed at predict time. Entries are
// popped and compared when the DUT resolves.
module tb_spec_bht;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [5:0] index;
    logic       spec_valid;
    logic [5:0] spec_index;
    logic       spec_taken;
    logic       res_valid;
    logic       res_taken;

    logic [5:0] out, g_out;
    logic       spec_ready, res_ready, res_mispredict, busy;
    logic       g_spec_ready, g_res_ready, g_res_mispredict, g_busy;
    logic [2:0] pending, g_pending;

    always #5 clk = ~clk;

    spec_bht #(.IWIDTH(6), .HWIDTH(6), .DEPTH(DEPTH), .GLOBAL(0)) dut (
        .clk(clk), .reset(reset), .en(en), .index(index), .out(out),
        .spec_valid(spec_valid), .spec_index(spec_index), .spec_taken(spec_taken),
        .spec_ready(spec_ready), .res_valid(res_valid), .res_taken(res_taken),
        .res_ready(res_ready), .res_mispredict(res_mispredict),
        .busy(busy), .pending(pending)
    );

    spec_bht #(.IWIDTH(6), .HWIDTH(6), .DEPTH(DEPTH), .GLOBAL(1)) dut_g (
        .clk(clk), .reset(reset), .en(en), .index(index), .out(g_out),
        .spec_valid(spec_valid), .spec_index(spec_index), .spec_taken(spec_taken),
        .spec_ready(g_spec_ready), .res_valid(res_valid), .res_taken(res_taken),
        .res_ready(g_res_ready), .res_mispredict(g_res_mispredict),
        .busy(g_busy), .pending(g_pending)
    );

    typedef struct packed {
        logic [383:0] snap;
        logic [5:0]   idx;
        logic         taken;
    } ckpt_t;

    logic [5:0] mtab [64];
    ckpt_t      sb_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [383:0] flat();
        logic [383:0] f;
        for (int i = 0; i < 64; i++) f[i*6 +: 6] = mtab[i];
        return f;
    endfunction

    task automatic unflat(input logic [383:0] f);
        for (int i = 0; i < 64; i++) mtab[i] = f[i*6 +: 6];
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) mtab[i] = '0;
        sb_q.delete();
    endtask

    // Sweep every index and compare against the model, then realign to
    // one unit after a rising edge.
    task automatic check_table(input string tag);
        for (int i = 0; i < 64; i++) begin
            index = 6'(i);
            #1;
            check($sformatf("%s tb[%0d]", tag, i), out, mtab[i]);
        end
        @(posedge clk); #1;
    endtask

    // One IDLE-state cycle of stimulus. Called one unit after a rising edge.
    // rep returns the expected repair length when a mispredict is taken.
    task automatic do_cycle(input logic sv, input logic [5:0] si, input logic st,
                            input logic rv, input logic rt, output int rep);
        logic  sr, rr, mp;
        ckpt_t h;
        spec_valid = sv; spec_index = si; spec_taken = st;
        res_valid  = rv; res_taken  = rt;
        #1;
        sr = en && (sb_q.size() != DEPTH);
        rr = en && (sb_q.size() != 0);
        check("spec_ready", spec_ready, sr);
        check("res_ready", res_ready, rr);
        mp = 1'b0;
        if (rv && rr) mp = (rt != sb_q[0].taken);
        check("res_mispredict", res_mispredict, mp);
        rep = 0;
        if (sv && sr) begin
            sb_q.push_back('{snap: flat(), idx: si, taken: st});
            mtab[si] = {mtab[si][4:0], st};
        end
        if (rv && rr) begin
            h = sb_q.pop_front();
            if (mp) begin
                rep = sb_q.size() + 1;
                unflat(h.snap);
                mtab[h.idx] = {mtab[h.idx][4:0], rt};
                sb_q.delete();
            end
        end
        @(posedge clk); #1;
        spec_valid = 1'b0;
        res_valid  = 1'b0;
        check("busy", busy, mp);
        check("pending", pending, mp ? rep : sb_q.size());
    endtask

    // Count cycles with busy high. Optionally stall for two of them.
    task automatic wait_repair(input int exp, input bit drop);
        int n = 0;
        while (busy && n < 64) begin
            n++;
            if (drop && n == 2) en = 1'b0;
            if (drop && n == 4) en = 1'b1;
            @(posedge clk); #1;
        end
        en = 1'b1;
        check("repair_cycles", n, exp);
        check("pending_after_repair", pending, 0);
        check("spec_ready_after_repair", spec_ready, 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int   rep;
        logic sv, st, rv, rt;
        logic [5:0] si;

        reset = 1'b0; en = 1'b1; index = '0;
        spec_valid = 1'b0; spec_index = '0; spec_taken = 1'b0;
        res_valid = 1'b1; res_taken = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        // Reset state, with res_valid held high to show it is ignored.
        check("rst out", out, 0);
        check("rst pending", pending, 0);
        check("rst busy", busy, 0);
        check("rst res_ready", res_ready, 0);
        check("rst res_mispredict", res_mispredict, 0);
        check("rst spec_ready", spec_ready, 1);
        res_valid = 1'b0;
        reset = 1'b1;

        // Single push, then a correct resolve.
        do_cycle(1, 6'd3, 1, 0, 0, rep);
        index = 6'd3; #1;
        check("push idx3 out", out, 6'b000001);
        @(posedge clk); #1;
        do_cycle(0, 6'd0, 0, 1, 1, rep);
        check_table("correct");

        // Three pushes with aliasing, then a mispredict on the oldest.
        do_reset();
        do_cycle(1, 6'd3, 1, 0, 0, rep);
        do_cycle(1, 6'd5, 1, 0, 0, rep);
        do_cycle(1, 6'd3, 0, 0, 0, rep);
        index = 6'd3; #1;
        check("alias idx3 out", out, 6'b000010);
        @(posedge clk); #1;
        do_cycle(0, 6'd0, 0, 1, 0, rep);
        wait_repair(3, 0);
        index = 6'd3; #1;
        check("repaired idx3", out, 6'b000000);
        index = 6'd5; #1;
        check("repaired idx5", out, 6'b000000);
        @(posedge clk); #1;
        check_table("mp3");

        // Fill to DEPTH, then push with a correct resolve: push refused.
        do_cycle(1, 6'd1, 1, 0, 0, rep);
        do_cycle(1, 6'd2, 0, 0, 0, rep);
        do_cycle(1, 6'd1, 0, 0, 0, rep);
        do_cycle(1, 6'd9, 1, 0, 0, rep);
        do_cycle(1, 6'd4, 1, 1, sb_q[0].taken, rep);
        check("full pending", pending, 3);

        // Push plus mispredict at the same edge, stalled mid-repair.
        do_cycle(1, 6'd1, 1, 1, ~sb_q[0].taken, rep);
        check("same-edge rep", rep, 4);
        wait_repair(6, 1);
        check_table("stall");

        // Reset in the middle of a repair.
        do_cycle(1, 6'd3, 1, 0, 0, rep);
        do_cycle(1, 6'd3, 0, 0, 0, rep);
        do_cycle(1, 6'd6, 1, 0, 0, rep);
        do_cycle(1, 6'd3, 1, 0, 0, rep);
        do_cycle(0, 6'd0, 0, 1, ~sb_q[0].taken, rep);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        #1;
        check("rst mid busy", busy, 0);
        check("rst mid pending", pending, 0);
        check_table("rst_mid");
        reset = 1'b1;

        // Mixed random traffic over a few aliasing indices.
        for (int it = 0; it < 60; it++) begin
            sv = 1'($urandom_range(0, 1));
            si = 6'($urandom_range(0, 7));
            st = 1'($urandom_range(0, 1));
            rv = 1'($urandom_range(0, 1));
            rt = 1'b0;
            if (sb_q.size() != 0)
                rt = ($urandom_range(0, 3) == 0) ? ~sb_q[0].taken : sb_q[0].taken;
            do_cycle(sv, si, st, rv, rt, rep);
            if (rep != 0) begin
                wait_repair(rep, 0);
                check_table("rand");
            end
        end
        check_table("rand_end");

        // Global-history instance.
        do_reset();
        spec_valid = 1'b1; spec_index = 6'd7; spec_taken = 1'b1;
        #1;
        check("g spec_ready", g_spec_ready, 1);
        @(posedge clk); #1;
        spec_index = 6'd2;
        @(posedge clk); #1;
        spec_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            index = (k == 0) ? 6'd0 : (k == 1) ? 6'd7 : (k == 2) ? 6'd2 : 6'd63;
            #1;
            check($sformatf("g out idx%0d", index), g_out, 6'b000011);
        end
        check("g pending", g_pending, 2);
        @(posedge clk); #1;
        res_valid = 1'b1; res_taken = 1'b0;
        #1;
        check("g mispredict", g_res_mispredict, 1);
        @(posedge clk); #1;
        res_valid = 1'b0;
        begin
            int n = 0;
            while (g_busy && n < 64) begin
                n++;
                @(posedge clk); #1;
            end
            check("g repair_cycles", n, 2);
        end
        index = 6'd7; #1;
        check("g out repaired", g_out, 6'b000000);
        index = 6'd40; #1;
        check("g out repaired any", g_out, 6'b000000);
        check("g pending after", g_pending, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_spec_bht

// File: doc/spec_bht.md
Name: spec_bht

Overview:
- Speculative branch history tracker; successor to the non-speculative local-history table.
- Shifts predicted outcomes into history at predict time and tracks in-flight branches in a checkpoint FIFO.
- Resolves them in program order; on a mispredict, restores the table exactly by a multi-cycle reverse walk.
- Sits between fetch-stage prediction (feeds PHT index hashing) and execute-stage branch resolution.

Parameters:
- IWIDTH, 6, table index width; table has 2**IWIDTH entries.
- HWIDTH, 6, history bits per entry; must be at least 2.
- DEPTH, 4, maximum in-flight branches; power of 2, at least 2.
- GLOBAL, 0, 1 = single global history register (all index inputs ignored, treated as 0); 0 = per-index local table.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- en  in  1  stall control; 0 freezes all state and forces both ready outputs to 0.
- index  in  IWIDTH  lookup index.
- out  out  HWIDTH  combinational table content at index, including accepted speculative updates.
- spec_valid  in  1  predicted branch offered.
- spec_index  in  IWIDTH  table index of that branch.
- spec_taken  in  1  predicted direction.
- spec_ready  out  1  en && state==IDLE && pending!=DEPTH.
- res_valid  in  1  oldest in-flight branch resolved.
- res_taken  in  1  actual direction.
- res_ready  out  1  en && state==IDLE && pending!=0.
- res_mispredict  out  1  combinational: res_valid && res_ready && res_taken != head predicted direction.
- busy  out  1  state==REPAIR.
- pending  out  $clog2(DEPTH)+1  in-flight count.

Behaviour:
- Reset (async, reset==0): all table entries 0, FIFO empty, state IDLE, internal repair pointer and latched direction cleared.
- Reset outputs: out=0, pending=0, busy=0, res_ready=0, res_mispredict=0, spec_ready=en.
- Reset asserted mid-REPAIR aborts the repair; the table is simply zeroed.
- Push (spec_valid && spec_ready at edge):
  - old = tb[spec_index]; tb[spec_index] <= {old[HWIDTH-2:0], spec_taken}.
  - FIFO appends {spec_index, old, spec_taken}; pending+1.
  - Visible on out from the next cycle.
- Correct resolve (res_valid && res_ready && !res_mispredict): pop head, table untouched, pending-1.
- Mispredict resolve:
  - Latch res_taken; set ptr = youngest entry (tail-1, mod DEPTH); state -> REPAIR.
  - The table is not written at this edge.
- REPAIR, one step per enabled cycle:
  - If ptr != head: tb[entry[ptr].index] <= entry[ptr].old; ptr-1 mod DEPTH.
  - If ptr == head: tb[head.index] <= {head.old[HWIDTH-2:0], latched res_taken}; FIFO cleared; pending=0; state -> IDLE.
  - Repair takes exactly pending cycles (count at REPAIR entry). busy is high during those cycles.
  - Reverse order restores aliased indices correctly.
- Simultaneous push and resolve in IDLE: both are accepted at the same edge.
  - With a correct resolve, pending is unchanged.
  - With a mispredict, the same-edge push is appended first and becomes the youngest entry, so it is rolled back too. The REPAIR count includes it.
- Full: spec_ready=0 even if a pop occurs the same cycle (no combinational ready path).
- Empty: res_ready=0; res_valid is ignored.
- en=0: no table, FIFO, pointer or state change. REPAIR pauses and resumes.
- All pointer arithmetic wraps mod DEPTH; pending saturation is impossible by the ready rules.
- GLOBAL=1: table size 1; out is the global history.

Decomposition:
- Package bht_pkg: state enum (IDLE, REPAIR).
- Parametrised FIFO entry struct {index, old history, predicted direction} is declared locally from IWIDTH/HWIDTH.
- Sub-module bht_ckpt_fifo: circular buffer with push, pop, clear, head read, and random read at ptr for the repair walk.

Test Plan:
- After reset release, push idx 3 taken -> next cycle out(idx 3)=000001, pending=1, busy=0.
- Resolve it with res_taken=1 -> res_mispredict=0, pending=0, tb[3] stays 000001.
- Push idx 3 T, idx 5 T, idx 3 NT (tb[3]=000010), then resolve res_taken=0 -> mispredict; busy high exactly 3 cycles; final tb[3]=000000, tb[5]=000000, pending=0, spec_ready=1.
- Push 4 branches -> pending=4, spec_ready=0; push + correct resolve same cycle -> push not accepted, pending=3.
- Mispredict with pending=4, drop en for 2 cycles mid-REPAIR -> busy held 6 cycles total; same final table. Repeat with reset asserted mid-REPAIR -> table all 0, busy=0 immediately.
- GLOBAL=1: push idx 7 T, then idx 2 T -> out=000011 for any index; mispredict on first -> after 2 cycles out=000000.
